// File: rtl/ps2_pkg.sv
// ps2_pkg: shared definitions for the PS/2 device-side transmitter.
//   ps2_state_t : transmitter FSM states
//   FRAME_BITS  : bits per PS/2 frame (start, 8 data, parity, stop)
//   STOP_IDX    : bit index of the stop cell
//   odd_parity  : parity bit that makes the 9-bit data+parity word odd
//   make_frame  : builds the frame, bit k is transmitted in cell k
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } ps2_state_t;

    localparam int         FRAME_BITS = 11;
    localparam logic [3:0] STOP_IDX   = 4'(FRAME_BITS - 1);

    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

    function automatic logic [FRAME_BITS-1:0] make_frame(input logic [7:0] d);
        return {1'b1, odd_parity(d), d, 1'b0};
    endfunction

endpackage

// File: rtl/ps2_tx_fifo.sv
// ps2_tx_fifo: small synchronous FIFO holding bytes waiting for transmission.
//   clk, resetn      : clock, synchronous active-low reset (empties the queue)
//   push, push_data  : write request; ignored while full
//   pop, pop_data    : read request; pop_data is the current head (show-ahead)
//   full, empty      : occupancy flags
// DEPTH must be a power of two so the pointers wrap naturally.
module ps2_tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      count_reg;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count_reg == (AW+1)'(DEPTH));
    assign empty   = (count_reg == '0);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;

    // Head is read combinationally so the transmitter can load the frame in
    // the same cycle it pops.
    assign pop_data = mem[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + (AW+1)'(1);
                2'b01:   count_reg <= count_reg - (AW+1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/ps2_device_tx.sv
// ps2_device_tx: PS/2 device-side byte transmitter (keyboard-style scan codes).
//   clk, resetn         : clock, synchronous active-low reset
//   in_valid, in_data   : byte offer, accepted when in_ready is high
//   in_ready            : byte queue not full
//   ps2_clk_in          : sensed PS/2 clock line (asynchronous), used to spot host inhibit
//   ps2_clk_o, ps2_data_o : driven PS/2 lines, 1 = released
//   busy                : a frame or its trailing gap is in progress
// Each bit cell is CLK_DIV cycles clock-high followed by CLK_DIV cycles
// clock-low; data changes only at the start of a cell. After each frame
// GAP_CELLS idle cells are inserted.
import ps2_pkg::*;

module ps2_device_tx #(
    parameter int CLK_DIV    = 2500,
    parameter int GAP_CELLS  = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    input  logic       ps2_clk_in,
    output logic       ps2_clk_o,
    output logic       ps2_data_o,
    output logic       busy
);

    localparam int CELL_LEN = 2 * CLK_DIV;
    localparam int CNT_W    = $clog2(CELL_LEN);
    localparam int GAP_LEN  = GAP_CELLS * CELL_LEN;
    localparam int GAP_W    = (GAP_LEN > 1) ? $clog2(GAP_LEN) : 1;

    ps2_state_t              state_reg, state_next;
    logic [CNT_W-1:0]        cnt_reg, cnt_next;
    logic [3:0]              bit_reg, bit_next;
    logic [GAP_W-1:0]        gap_reg, gap_next;
    logic [FRAME_BITS-1:0]   frame_reg, frame_next;
    logic                    retry_reg, retry_next;
    logic                    clk_o_reg, clk_o_next;
    logic                    data_o_reg, data_o_next;
    logic                    busy_reg, busy_next;
    logic [1:0]              sync_reg;
    logic                    inhibit;
    logic                    pop;
    logic [7:0]              head;
    logic                    fifo_full;
    logic                    fifo_empty;

    ps2_tx_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .resetn    (resetn),
        .push      (in_valid),
        .push_data (in_data),
        .pop       (pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign in_ready   = ~fifo_full;
    assign ps2_clk_o  = clk_o_reg;
    assign ps2_data_o = data_o_reg;
    assign busy       = busy_reg;

    // Synchroniser resets to the released level so reset never looks like inhibit.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            sync_reg <= 2'b11;
        end else begin
            sync_reg <= {sync_reg[0], ps2_clk_in};
        end
    end

    // The host can only be heard pulling the clock low while we release it.
    assign inhibit = ~sync_reg[1] & clk_o_reg;

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        bit_next   = bit_reg;
        gap_next   = gap_reg;
        frame_next = frame_reg;
        retry_next = retry_reg;
        pop        = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (!inhibit) begin
                    if (retry_reg) begin
                        // Resend the aborted byte still held in frame_reg.
                        state_next = ST_SHIFT;
                        retry_next = 1'b0;
                        cnt_next   = '0;
                        bit_next   = '0;
                    end else if (!fifo_empty) begin
                        pop        = 1'b1;
                        frame_next = make_frame(head);
                        state_next = ST_SHIFT;
                        cnt_next   = '0;
                        bit_next   = '0;
                    end
                end
            end
            ST_SHIFT: begin
                if (inhibit && (bit_reg != STOP_IDX)) begin
                    state_next = ST_IDLE;
                    retry_next = 1'b1;
                    cnt_next   = '0;
                    bit_next   = '0;
                end else if (cnt_reg == CNT_W'(CELL_LEN - 1)) begin
                    cnt_next = '0;
                    if (bit_reg == STOP_IDX) begin
                        bit_next   = '0;
                        gap_next   = '0;
                        state_next = (GAP_LEN == 0) ? ST_IDLE : ST_GAP;
                    end else begin
                        bit_next = bit_reg + 4'd1;
                    end
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            ST_GAP: begin
                if (gap_reg == GAP_W'(GAP_LEN - 1)) begin
                    gap_next = '0;
                    // Start the next queued byte directly so consecutive frames
                    // are separated by exactly the gap, with no extra idle cycle.
                    if (!inhibit && !fifo_empty) begin
                        pop        = 1'b1;
                        frame_next = make_frame(head);
                        state_next = ST_SHIFT;
                        cnt_next   = '0;
                        bit_next   = '0;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end else begin
                    gap_next = gap_reg + GAP_W'(1);
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        // Outputs are registered from the next state so the lines never glitch.
        clk_o_next  = 1'b1;
        data_o_next = 1'b1;
        if (state_next == ST_SHIFT) begin
            clk_o_next  = (cnt_next < CNT_W'(CLK_DIV));
            data_o_next = frame_next[bit_next];
        end
        busy_next = (state_next != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_reg  <= ST_IDLE;
            cnt_reg    <= '0;
            bit_reg    <= '0;
            gap_reg    <= '0;
            frame_reg  <= '0;
            retry_reg  <= 1'b0;
            clk_o_reg  <= 1'b1;
            data_o_reg <= 1'b1;
            busy_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            bit_reg    <= bit_next;
            gap_reg    <= gap_next;
            frame_reg  <= frame_next;
            retry_reg  <= retry_next;
            clk_o_reg  <= clk_o_next;
            data_o_reg <= data_o_next;
            busy_reg   <= busy_next;
        end
    end

endmodule

// File: tb/tb_ps2_device_tx.sv
// tb_ps2_device_tx: directed bench for ps2_device_tx with CLK_DIV=4, GAP_CELLS=2.
// A PS/2 receiver model samples data on each falling edge of ps2_clk_o and
// decodes complete frames; directed tests compare against hand-derived values.
module tb_ps2_device_tx;

    logic       clk = 1'b0;
    logic       resetn;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       ps2_clk_in;
    logic       ps2_clk_o;
    logic       ps2_data_o;
    logic       busy;

    int vec_cnt = 0;
    int err_cnt = 0;

    // Receiver model state (written only by the monitor process)
    int          cyc         = 0;
    int          bit_cnt     = 0;
    int          edge_total  = 0;
    int          abort_bits  = 0;
    int          busy_cycles = 0;
    int          glitch_cnt  = 0;
    int          rx_bad      = 0;
    int          first_edge  = 0;
    logic [10:0] shreg       = '0;
    logic [10:0] last_bits   = '0;
    logic        prev_clk    = 1'b1;
    logic        prev_data   = 1'b1;
    logic [7:0]  rx_q [$];
    int          fe_q [$];
    int          le_q [$];

    ps2_device_tx #(
        .CLK_DIV    (4),
        .GAP_CELLS  (2),
        .FIFO_DEPTH (4)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .ps2_clk_in (ps2_clk_in),
        .ps2_clk_o  (ps2_clk_o),
        .ps2_data_o (ps2_data_o),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    initial begin : monitor
        forever begin
            @(negedge clk);
            cyc++;
            if (busy) busy_cycles++;
            if (!prev_clk && !ps2_clk_o && (ps2_data_o != prev_data)) glitch_cnt++;
            if (prev_clk && !ps2_clk_o) begin
                edge_total++;
                if (bit_cnt == 0) first_edge = cyc;
                shreg[bit_cnt] = ps2_data_o;
                bit_cnt++;
                if (bit_cnt == 11) begin
                    last_bits = shreg;
                    rx_q.push_back(shreg[8:1]);
                    fe_q.push_back(first_edge);
                    le_q.push_back(cyc);
                    if (shreg[0] != 1'b0 || shreg[10] != 1'b1 || shreg[9] != ~^shreg[8:1])
                        rx_bad++;
                    bit_cnt = 0;
                end
            end else if (!busy && bit_cnt != 0) begin
                abort_bits = bit_cnt;
                bit_cnt    = 0;
            end
            prev_clk  = ps2_clk_o;
            prev_data = ps2_data_o;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end else begin
            $display("vec %0d %s: %0h ok", vec_cnt, tag, got);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] d, output logic acc);
        in_valid = 1'b1;
        in_data  = d;
        acc      = in_ready;
        step();
        in_valid = 1'b0;
    endtask

    task automatic wait_rx(input int n, input int budget);
        int k = 0;
        while (rx_q.size() < n && k < budget) begin
            step();
            k++;
        end
        check_val("rx_wait", 32'(rx_q.size() >= n), 32'd1);
    endtask

    task automatic wait_edges(input int target, input int budget);
        int k = 0;
        while (edge_total < target && k < budget) begin
            step();
            k++;
        end
        check_val("edge_wait", 32'(edge_total >= target), 32'd1);
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        while (busy && k < budget) begin
            step();
            k++;
        end
        check_val("idle_wait", 32'(busy), 32'd0);
    endtask

    initial begin : stim
        logic       acc;
        int         n0, b0, c0, e0;
        logic [7:0] pat [6];

        resetn     = 1'b0;
        in_valid   = 1'b0;
        in_data    = 8'h00;
        ps2_clk_in = 1'b1;
        repeat (3) step();

        check_val("rst_clk_o",  32'(ps2_clk_o),  32'd1);
        check_val("rst_data_o", 32'(ps2_data_o), 32'd1);
        check_val("rst_busy",   32'(busy),       32'd0);
        check_val("rst_ready",  32'(in_ready),   32'd1);
        resetn = 1'b1;
        repeat (4) step();

        // Single byte 1C: cell data 0,0,0,1,1,1,0,0,0,0,1
        n0 = rx_q.size();
        b0 = busy_cycles;
        c0 = cyc;
        push_byte(8'h1C, acc);
        check_val("t1_accept", 32'(acc), 32'd1);
        wait_rx(n0 + 1, 400);
        wait_idle(100);
        check_val("t1_byte",      32'(rx_q[n0]), 32'h1C);
        check_val("t1_bits",      32'(last_bits), 32'h438);
        check_val("t1_first_edge", 32'(fe_q[n0] - c0), 32'd6);
        check_val("t1_span",      32'(le_q[n0] - fe_q[n0]), 32'd80);
        check_val("t1_busy_cyc",  32'(busy_cycles - b0), 32'd104);

        // Back-to-back F0, 1C: 16 idle cycles between stop cell and start cell
        repeat (5) step();
        n0 = rx_q.size();
        push_byte(8'hF0, acc);
        push_byte(8'h1C, acc);
        wait_rx(n0 + 2, 600);
        wait_idle(100);
        check_val("t2_byte0", 32'(rx_q[n0]),     32'hF0);
        check_val("t2_byte1", 32'(rx_q[n0 + 1]), 32'h1C);
        check_val("t2_gap",   32'(fe_q[n0 + 1] - le_q[n0]), 32'd24);

        // Queue fill: five accepted (one into SHIFT, four queued), sixth dropped
        repeat (5) step();
        n0 = rx_q.size();
        pat[0] = 8'h11; pat[1] = 8'h22; pat[2] = 8'h33;
        pat[3] = 8'h44; pat[4] = 8'h55; pat[5] = 8'h66;
        for (int i = 0; i < 6; i++) begin
            push_byte(pat[i], acc);
            check_val($sformatf("t3_accept%0d", i), 32'(acc), (i < 5) ? 32'd1 : 32'd0);
        end
        wait_rx(n0 + 5, 1000);
        wait_idle(100);
        for (int i = 0; i < 5; i++) begin
            check_val($sformatf("t3_byte%0d", i), 32'(rx_q[n0 + i]), 32'(pat[i]));
        end
        repeat (200) step();
        check_val("t3_no_extra", 32'(rx_q.size()), 32'(n0 + 5));
        check_val("t3_ready",    32'(in_ready), 32'd1);

        // Host inhibit during cell 4 clock-high: abort, then full resend
        n0 = rx_q.size();
        e0 = edge_total;
        push_byte(8'h1C, acc);
        wait_edges(e0 + 4, 200);
        begin
            int k = 0;
            while (!ps2_clk_o && k < 20) begin
                step();
                k++;
            end
        end
        ps2_clk_in = 1'b0;
        repeat (40) step();
        check_val("t4_clk_o",   32'(ps2_clk_o),  32'd1);
        check_val("t4_data_o",  32'(ps2_data_o), 32'd1);
        check_val("t4_busy",    32'(busy),       32'd0);
        check_val("t4_edges",   32'(edge_total - e0), 32'd4);
        check_val("t4_abort",   32'(abort_bits), 32'd4);
        check_val("t4_no_rx",   32'(rx_q.size()), 32'(n0));
        ps2_clk_in = 1'b1;
        wait_rx(n0 + 1, 400);
        wait_idle(100);
        check_val("t4_resend",  32'(rx_q[n0]), 32'h1C);
        check_val("t4_edges2",  32'(edge_total - e0), 32'd15);

        // Reset during cell 6 abandons the frame and the queued byte
        repeat (5) step();
        n0 = rx_q.size();
        e0 = edge_total;
        push_byte(8'h55, acc);
        push_byte(8'hAA, acc);
        wait_edges(e0 + 7, 200);
        resetn = 1'b0;
        step();
        check_val("t5_clk_o",  32'(ps2_clk_o),  32'd1);
        check_val("t5_data_o", 32'(ps2_data_o), 32'd1);
        check_val("t5_busy",   32'(busy),       32'd0);
        check_val("t5_ready",  32'(in_ready),   32'd1);
        resetn = 1'b1;
        repeat (300) step();
        check_val("t5_no_rx",    32'(rx_q.size()), 32'(n0));
        check_val("t5_no_edges", 32'(edge_total - e0), 32'd7);
        check_val("t5_idle",     32'(busy), 32'd0);

        check_val("framing_errs", 32'(rx_bad),     32'd0);
        check_val("data_glitch",  32'(glitch_cnt), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
